// File: rtl/snake_body_engine.sv
// Snake body datapath: ring buffer of segment cells, one-cell advance per step,
// look-ahead collision, growth and pixel query. Define SNAKE_WRAP_EN for wrapping edges.
module snake_body_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int XW       = 5,
  parameter int YW       = 5,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            SCEN,
  input  logic                            Init,
  input  logic [1:0]                      Dirn,
  input  logic [XW-1:0]                   Food_X,
  input  logic [YW-1:0]                   Food_Y,
  input  logic                            Food_Valid,
  output logic                            Collide,
  output logic                            Full,
  output logic                            Ate,
  output logic [XW-1:0]                   Head_X,
  output logic [YW-1:0]                   Head_Y,
  output logic [$clog2(MAX_LEN+1)-1:0]    Length,
  input  logic [XW-1:0]                   Qry_X,
  input  logic [YW-1:0]                   Qry_Y,
  output logic                            Qry_Hit,
  output logic                            Qry_Head
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [XW:0] X_ONE  = 1;
  localparam logic [YW:0] Y_ONE  = 1;
  localparam logic [XW:0] X_LAST = (XW+1)'(GRID_W - 1);
  localparam logic [YW:0] Y_LAST = (YW+1)'(GRID_H - 1);
  localparam logic [XW:0] X_WID  = (XW+1)'(GRID_W);
  localparam logic [YW:0] Y_WID  = (YW+1)'(GRID_H);

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [PW-1:0] hp, hp_dec;
  logic [LW-1:0] len_q, len_nx;
  logic          full_q, ate_q;

  logic [XW:0]   nx_raw;
  logic [YW:0]   ny_raw;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          wall_hit, grow, self_hit, qry_hit, step_en;

  // Candidate head is formed one bit wider so stepping off edge 0 shows up as all-ones.
  always_comb begin : next_head
    nx_raw = {1'b0, seg_x[hp]};
    ny_raw = {1'b0, seg_y[hp]};
    case (Dirn)
      2'b00:   ny_raw = {1'b0, seg_y[hp]} - Y_ONE;
      2'b01:   ny_raw = {1'b0, seg_y[hp]} + Y_ONE;
      2'b10:   nx_raw = {1'b0, seg_x[hp]} - X_ONE;
      default: nx_raw = {1'b0, seg_x[hp]} + X_ONE;
    endcase
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
    if (nx_raw == X_WID)      nx = '0;
    else if (nx_raw > X_LAST) nx = X_LAST[XW-1:0];
    else                      nx = nx_raw[XW-1:0];
    if (ny_raw == Y_WID)      ny = '0;
    else if (ny_raw > Y_LAST) ny = Y_LAST[YW-1:0];
    else                      ny = ny_raw[YW-1:0];
`else
    wall_hit = (nx_raw > X_LAST) || (ny_raw > Y_LAST);
    nx = nx_raw[XW-1:0];
    ny = ny_raw[YW-1:0];
`endif
    grow = Food_Valid && (nx == Food_X) && (ny == Food_Y);
  end

  // Each slot's segment index is its distance from hp around the ring.
  always_comb begin : body_scan
    logic [PW-1:0] k;
    logic          occ;
    logic          tail;
    self_hit = 1'b0;
    qry_hit  = 1'b0;
    k        = '0;
    occ      = 1'b0;
    tail     = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (PW'(i) >= hp) k = PW'(i) - hp;
      else              k = PW'(i) + PW'(MAX_LEN) - hp;
      occ  = LW'(k) < len_q;
      tail = LW'(k) == (len_q - LW'(1));
      // The tail cell is vacated by a non-growing step, so moving into it is legal.
      if (occ && !(tail && !grow) && (seg_x[i] == nx) && (seg_y[i] == ny))
        self_hit = 1'b1;
      if (occ && (seg_x[i] == Qry_X) && (seg_y[i] == Qry_Y))
        qry_hit = 1'b1;
    end
  end

  assign Collide = wall_hit | self_hit;

  // SCEN is a one-cycle strobe with no back-pressure: a step is taken on the edge
  // where SCEN is high unless Init, Collide or Full blocks it in that same cycle.
  assign step_en = SCEN & ~Init & ~Collide & ~full_q;
  assign hp_dec  = (hp == '0) ? PW'(MAX_LEN - 1) : hp - PW'(1);
  assign len_nx  = (step_en && grow) ? len_q + LW'(1) : len_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hp     <= '0;
      len_q  <= LW'(INIT_LEN);
      full_q <= 1'b0;
      ate_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= XW'(START_X);
        seg_y[i] <= YW'(START_Y + i);
      end
    end else if (Init) begin
      hp     <= '0;
      len_q  <= LW'(INIT_LEN);
      full_q <= 1'b0;
      ate_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= XW'(START_X);
        seg_y[i] <= YW'(START_Y + i);
      end
    end else begin
      ate_q  <= step_en && grow;
      full_q <= (len_nx == LW'(MAX_LEN));
      if (step_en) begin
        hp            <= hp_dec;
        seg_x[hp_dec] <= nx;
        seg_y[hp_dec] <= ny;
        len_q         <= len_nx;
      end
    end
  end

  assign Head_X   = seg_x[hp];
  assign Head_Y   = seg_y[hp];
  assign Length   = len_q;
  assign Full     = full_q;
  assign Ate      = ate_q;
  assign Qry_Hit  = qry_hit;
  assign Qry_Head = (seg_x[hp] == Qry_X) && (seg_y[hp] == Qry_Y);

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: vector table, hand-written corner sequences and a
// randomized run against a queue-based model of the snake.
module tb_snake_body_engine;

  localparam int GRID_W   = 32;
  localparam int GRID_H   = 24;
  localparam int XW       = 5;
  localparam int YW       = 5;
  localparam int MAX_LEN  = 16;
  localparam int INIT_LEN = 3;
  localparam int START_X  = 16;
  localparam int START_Y  = 12;
  localparam int LW       = $clog2(MAX_LEN + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          scen, init, food_valid;
  logic [1:0]    dirn;
  logic [XW-1:0] food_x, qry_x, head_x;
  logic [YW-1:0] food_y, qry_y, head_y;
  logic          collide, full, ate, qry_hit, qry_head;
  logic [LW-1:0] length;

  snake_body_engine #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW), .MAX_LEN(MAX_LEN),
    .INIT_LEN(INIT_LEN), .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .Clk(clk), .Reset(rst), .SCEN(scen), .Init(init), .Dirn(dirn),
    .Food_X(food_x), .Food_Y(food_y), .Food_Valid(food_valid),
    .Collide(collide), .Full(full), .Ate(ate),
    .Head_X(head_x), .Head_Y(head_y), .Length(length),
    .Qry_X(qry_x), .Qry_Y(qry_y), .Qry_Hit(qry_hit), .Qry_Head(qry_head)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: body as a queue, head at index 0 ----------------
  int bx[$];
  int by[$];
  bit m_ate, m_full;

  function automatic void m_init();
    bx.delete();
    by.delete();
    for (int k = 0; k < INIT_LEN; k++) begin
      bx.push_back(START_X);
      by.push_back(START_Y + k);
    end
    m_ate  = 1'b0;
    m_full = 1'b0;
  endfunction

  function automatic void m_next(input logic [1:0] d, output int x, output int y);
    x = bx[0];
    y = by[0];
    case (d)
      2'b00:   y = y - 1;
      2'b01:   y = y + 1;
      2'b10:   x = x - 1;
      default: x = x + 1;
    endcase
`ifdef SNAKE_WRAP_EN
    x = (x + GRID_W) % GRID_W;
    y = (y + GRID_H) % GRID_H;
`endif
  endfunction

  function automatic bit m_collide(input logic [1:0] d, input bit fv, input int fx, input int fy);
    int  x, y;
    bit  g;
    m_next(d, x, y);
    if (x < 0 || x >= GRID_W || y < 0 || y >= GRID_H) return 1'b1;
    g = fv && (x == fx) && (y == fy);
    for (int k = 0; k < bx.size(); k++) begin
      if (k == bx.size() - 1 && !g) continue;
      if (bx[k] == x && by[k] == y) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void m_step(input bit s, input bit in, input logic [1:0] d,
                                 input bit fv, input int fx, input int fy);
    int x, y;
    bit g;
    if (in) begin
      m_init();
    end else begin
      m_ate = 1'b0;
      if (s && !m_full && !m_collide(d, fv, fx, fy)) begin
        m_next(d, x, y);
        g = fv && (x == fx) && (y == fy);
        bx.push_front(x);
        by.push_front(y);
        if (!g) begin
          void'(bx.pop_back());
          void'(by.pop_back());
        end
        m_ate  = g;
        m_full = (bx.size() == MAX_LEN);
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input bit s, input bit in, input logic [1:0] d, input bit fv,
                       input int fx, input int fy, output bit col_pre);
    @(negedge clk);
    scen       = s;
    init       = in;
    dirn       = d;
    food_valid = fv;
    food_x     = XW'(fx);
    food_y     = YW'(fy);
    #1 col_pre = collide;
    @(posedge clk);
    m_step(s, in, d, fv, fx, fy);
    #1;
    scen = 1'b0;
    init = 1'b0;
  endtask

  task automatic query(input int x, input int y, output bit hit, output bit hd);
    qry_x = XW'(x);
    qry_y = YW'(y);
    #1;
    hit = qry_hit;
    hd  = qry_head;
  endtask

  task automatic chk_state(input string tag, input int hx, input int hy, input int ln,
                           input int at, input int fl);
    chk({tag, "_head_x"}, int'(head_x), hx);
    chk({tag, "_head_y"}, int'(head_y), hy);
    chk({tag, "_length"}, int'(length), ln);
    chk({tag, "_ate"},    int'(ate), at);
    chk({tag, "_full"},   int'(full), fl);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         scen;
    bit         init;
    logic [1:0] dir;
    bit         fv;
    int         fx;
    int         fy;
    int         e_col;
    int         e_hx;
    int         e_hy;
    int         e_len;
    int         e_ate;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit in, input int d, input bit fv,
                              input int fx, input int fy, input int ec, input int hx,
                              input int hy, input int ln, input int at);
    vec_t v;
    v.scen = s;  v.init = in; v.dir = 2'(d); v.fv = fv; v.fx = fx; v.fy = fy;
    v.e_col = ec; v.e_hx = hx; v.e_hy = hy; v.e_len = ln; v.e_ate = at;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bit col, hit, hd;
    bit exp_col, fv, s, in;
    logic [1:0] d;
    int fx, fy, qx, qy, k;

    rst = 1'b1; scen = 1'b0; init = 1'b0; dirn = 2'b00;
    food_valid = 1'b0; food_x = '0; food_y = '0; qry_x = '0; qry_y = '0;

    // Reset state, visible while Reset is still high
    #2;
    chk_state("reset", START_X, START_Y, INIT_LEN, 0, 0);
    chk("reset_collide", int'(collide), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_init();

    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 16, 12, 3, 0));
    for (int i = 1; i <= 12; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16, 12 - i, 3, 0));
`ifdef SNAKE_WRAP_EN
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16, 23, 3, 0));
`else
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 16, 0, 3, 0));
`endif
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 16, 12, 3, 0));
    tbl.push_back(mk(1, 0, 0, 1, 16, 11, 0, 16, 11, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16, 11, 4, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 16, 12, 3, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].scen, tbl[i].init, tbl[i].dir, tbl[i].fv, tbl[i].fx, tbl[i].fy, col);
      chk($sformatf("tbl%0d_collide", i), int'(col), tbl[i].e_col);
      chk($sformatf("tbl%0d_head_x", i), int'(head_x), tbl[i].e_hx);
      chk($sformatf("tbl%0d_head_y", i), int'(head_y), tbl[i].e_hy);
      chk($sformatf("tbl%0d_length", i), int'(length), tbl[i].e_len);
      chk($sformatf("tbl%0d_ate", i), int'(ate), tbl[i].e_ate);
    end

    // Pixel query on the initial snake
    query(16, 14, hit, hd); chk("q_tail_hit", int'(hit), 1); chk("q_tail_head", int'(hd), 0);
    query(16, 15, hit, hd); chk("q_below_hit", int'(hit), 0);
    query(16, 12, hit, hd); chk("q_head_hit", int'(hit), 1); chk("q_head_head", int'(hd), 1);

    // Self hit inside a 2x2 loop of a length-5 snake
    apply(0, 1, 0, 0, 0, 0, col);
    apply(1, 0, 0, 1, 16, 11, col);
    query(16, 14, hit, hd); chk("eat_tail_kept", int'(hit), 1);
    apply(1, 0, 0, 1, 16, 10, col);
    apply(1, 0, 3, 0, 0, 0, col);
    apply(1, 0, 1, 0, 0, 0, col);
    chk_state("loop", 17, 11, 5, 0, 0);
    apply(1, 0, 2, 0, 0, 0, col);
    chk("loop_left_collide", int'(col), 1);
    chk_state("loop_frozen", 17, 11, 5, 0, 0);
    apply(1, 0, 0, 0, 0, 0, col);
    chk("loop_neck_collide", int'(col), 1);
    chk_state("loop_frozen2", 17, 11, 5, 0, 0);

    // Tail chase with a length-4 snake; growing into the tail is a hit
    apply(0, 1, 0, 0, 0, 0, col);
    apply(1, 0, 0, 1, 16, 11, col);
    apply(1, 0, 3, 0, 0, 0, col);
    apply(1, 0, 1, 0, 0, 0, col);
    apply(0, 0, 2, 1, 16, 12, col);
    chk("tail_grow_collide", int'(col), 1);
    apply(1, 0, 2, 0, 0, 0, col);
    chk("tail_chase_collide", int'(col), 0);
    chk_state("tail_chase", 16, 12, 4, 0, 0);

    // Grow to MAX_LEN, then steps freeze
    apply(0, 1, 0, 0, 0, 0, col);
    for (int i = 1; i <= 12; i++) apply(1, 0, 0, 1, 16, 12 - i, col);
    chk_state("pre_full", 16, 0, 15, 1, 0);
    apply(1, 0, 3, 1, 17, 0, col);
    chk_state("full", 17, 0, 16, 1, 1);
    apply(1, 0, 3, 0, 0, 0, col);
    chk_state("full_frozen", 17, 0, 16, 0, 1);

    // Asynchronous reset mid-step
    @(negedge clk);
    scen = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_state("async_reset", START_X, START_Y, INIT_LEN, 0, 0);
    scen = 1'b0;
    #1 rst = 1'b0;
    m_init();

    // Randomized run against the model
    for (int n = 0; n < 600; n++) begin
      d = 2'($urandom_range(3));
      if ($urandom_range(3) != 0) begin
        for (int t = 0; t < 4 && m_collide(d, 1'b0, 0, 0); t++)
          d = 2'($urandom_range(3));
      end
      if ($urandom_range(2) == 0) begin
        m_next(d, fx, fy);
        fv = 1'b1;
      end else begin
        fx = $urandom_range(GRID_W - 1);
        fy = $urandom_range(GRID_H - 1);
        fv = 1'($urandom_range(1));
      end
      fx = fx & ((1 << XW) - 1);
      fy = fy & ((1 << YW) - 1);
      in = ($urandom_range(39) == 0);
      s  = ($urandom_range(3) != 0);
      exp_col = m_collide(d, fv, fx, fy);
      apply(s, in, d, fv, fx, fy, col);
      chk("rnd_collide", int'(col), int'(exp_col));
      chk_state("rnd", bx[0], by[0], bx.size(), int'(m_ate), int'(m_full));
      if ($urandom_range(1) == 1) begin
        k  = $urandom_range(bx.size() - 1);
        qx = bx[k];
        qy = by[k];
      end else begin
        qx = $urandom_range(GRID_W - 1);
        qy = $urandom_range(GRID_H - 1);
      end
      query(qx, qy, hit, hd);
      exp_col = 1'b0;
      foreach (bx[j]) if (bx[j] == qx && by[j] == qy) exp_col = 1'b1;
      chk("rnd_qry_hit", int'(hit), int'(exp_col));
      chk("rnd_qry_head", int'(hd), int'(bx[0] == qx && by[0] == qy));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Datapath stage directly downstream of the game state machine: consumes its direction code and step strobe, stores every snake segment coordinate in a ring buffer, and advances the body one cell per step. It computes look-ahead `Collide` (wall or self) and registered `Full` flags for the state machine, and `Ate` for the food generator. A combinational pixel-query port feeds the VGA renderer.

## Interface
- `GRID_W`, 32: grid columns; x range 0..GRID_W-1.
- `GRID_H`, 24: grid rows; y range 0..GRID_H-1; y=0 is the top row.
- `XW`, 5: x coordinate width.
- `YW`, 5: y coordinate width.
- `MAX_LEN`, 16: ring buffer depth and win length.
- `INIT_LEN`, 3: length after init; 1 ≤ INIT_LEN < MAX_LEN.
- `START_X`, 16 / `START_Y`, 12: head cell after init.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high reset.
- `SCEN` in 1: single-cycle step strobe; the same strobe the state machine samples.
- `Init` in 1: level; reload the initial snake, driven from the state machine's idle-state flag.
- `Dirn` in 2: movement direction. 00 = up (y-1), 01 = down (y+1), 10 = left (x-1), 11 = right (x+1).
- `Food_X` in XW / `Food_Y` in YW / `Food_Valid` in 1: current food cell.
- `Collide` out 1: combinational; the next step would hit a wall or the body.
- `Full` out 1: registered; high when Length == MAX_LEN.
- `Ate` out 1: registered one-cycle pulse after a growing step.
- `Head_X` out XW / `Head_Y` out YW: current head cell.
- `Length` out clog2(MAX_LEN+1): current segment count.
- `Qry_X` in XW / `Qry_Y` in YW: VGA cell query.
- `Qry_Hit` out 1 / `Qry_Head` out 1: combinational; query cell is a body segment / is the head.

## Operation
- **Storage.** Ring buffer `seg[0..MAX_LEN-1]` of {x,y} entries plus head pointer `hp`. Segment k (0 = head) lives at `seg[(hp+k) mod MAX_LEN]` and is valid for k < Length.
- **Init or reset.**
  - hp = 0; Length = INIT_LEN.
  - Segment k = (START_X, START_Y+k), a vertical body below the head, facing up.
  - Ate = 0. Full = 0.
- **Next head.** nx/ny = head offset by `Dirn`, computed in XW+1/YW+1 bits so the -1 underflow at edge 0 is detectable.
- **Wall hit.** nx outside 0..GRID_W-1, or ny outside 0..GRID_H-1.
- **Grow.** `Food_Valid` and (nx,ny) == (Food_X,Food_Y).
- **Self hit.** (nx,ny) equals a valid segment k. The tail segment k = Length-1 is excluded unless Grow, because the tail vacates in the same step.
- **Collide** = wall hit OR self hit; it is evaluated continuously from current state.
- **Step.** On SCEN with Init=0, Collide=0 and Full=0:
  - hp ← hp-1 mod MAX_LEN; the new head slot ← (nx,ny).
  - If Grow: Length ← Length+1 and Ate ← 1. Otherwise Length is unchanged, so the tail drops implicitly.
- **Frozen steps.** SCEN while Collide=1 or Full=1 leaves all state unchanged. The state machine moves to LOSE/WIN on that same edge.
- **Priority.** Reset > Init > step.
- **Ate** clears on every cycle that is not a growing step.
- **Full** is registered from the next Length value.

## Timing
- Collide depends only on registered state plus `Dirn`/`Food_*`. It is valid in the SCEN cycle, so the state machine and this block agree on the same edge.
- Step latency: Head_X/Head_Y, Length, Ate and Full update one edge after the SCEN cycle.
- Qry_Hit/Qry_Head are combinational with zero latency and reflect post-edge state.
- Reset values for an asynchronous Reset at any time, including mid-step:
  - Head = (START_X, START_Y); Length = INIT_LEN.
  - Full = 0; Ate = 0.
  - Collide then follows from the reset state.
- Init held high for multiple cycles keeps the snake in the initial position, and SCEN is ignored.
- Length saturates at MAX_LEN. Growth into the last slot sets Full, and later steps are frozen.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - Edges wrap: x = -1 → GRID_W-1, x = GRID_W → 0, and likewise for y.
  - Wall hit is never asserted; Collide = self hit only.
- `SNAKE_WRAP_EN` undefined: edges are walls as described in Operation.

## Test plan
- **Reset/init.** Reset, then Init for 1 cycle, Dirn=00 → head (16,12), Length 3, Qry (16,14) → Qry_Hit=1, Qry (16,15) → Qry_Hit=0, Collide=0.
- **Step up.** 12 SCEN pulses with Dirn=00 → head (16,0), Collide=1 in the following cycle.
  - Without `SNAKE_WRAP_EN`: a 13th SCEN leaves head at (16,0).
  - With `SNAKE_WRAP_EN`: Collide stays 0 and the 13th SCEN moves head to (16,23).
- **Eat.** Food (16,11) valid, one SCEN up → head (16,11), Length 4, Ate high for exactly 1 cycle, segment (16,14) still occupied.
- **Self hit vs tail chase.**
  - Length 5 snake in a 2×2 loop: the move into the neck → Collide=1.
  - Length 4 snake, move into the current tail cell → Collide=0 and the step succeeds.
- **Full.** MAX_LEN=4, INIT_LEN=3; eat once → Full=1 one edge later, then further SCEN → no change.
- **Priority.** Init and SCEN in the same cycle → initial snake restored with no step. Reset asserted mid-run for 1 ns → outputs take reset values immediately.
